rgb_pwm_sequencer: RTL
======================

RGB_PWM_SEQUENCER -- requirements
Module: rgb_pwm_sequencer

Interface
REQ-001 Parameter NUM_CH, 3: number of LED channels, 1..8.
REQ-002 Parameter PWM_W, 8: PWM counter and duty width.
REQ-003 Parameter DUTY_MAX, 255: peak duty, 1..2^PWM_W-1.
REQ-004 Parameter PRESC_MAX, 46874: sequencer tick every PRESC_MAX+1 clocks.
REQ-005 Parameter HOLD_TICKS, 64: ticks at peak duty, 1..65535.
REQ-006 int_osc  in  1  clock, all logic on rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 enable  in  1  run request; level-sensitive.
REQ-009 mode  in  1  0 = blink (duty steps), 1 = breathe (duty ramps).
REQ-010 pwm  out  NUM_CH  per-channel PWM, intended for SB_RGBA_DRV RGBnPWM inputs.
REQ-011 step  out  $clog2(NUM_CH+1)  current step; values 0..NUM_CH-1 select a channel, NUM_CH is the all-off step.
REQ-012 step_done  out  1  one-cycle pulse on step advance.
REQ-013 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-014 PWM counter SHALL be PWM_W bits, free-running +1 per clock, wrapping 2^PWM_W-1 -> 0.
REQ-015 Prescaler SHALL count 0..PRESC_MAX, held at 0 in IDLE; tick = 1 for the cycle when count == PRESC_MAX, then count -> 0.
REQ-016 pwm[i] SHALL be registered: pwm[i] <= (state != IDLE) && (step == i) && (pwm_cnt < duty); one-cycle latency.
REQ-017 duty == 0 -> channel constantly low; duty == 2^PWM_W-1 -> low one cycle per PWM frame.
REQ-018 FSM states SHALL be IDLE, RAMP_UP, HOLD, RAMP_DOWN, NEXT.
REQ-019 IDLE: duty = 0, step = 0; enable = 1 -> RAMP_UP next cycle; mode sampled into mode_q on exit.
REQ-020 RAMP_UP on tick: duty == DUTY_MAX -> HOLD (hold count cleared); else duty <= mode_q ? duty+1 : DUTY_MAX.
REQ-021 HOLD: hold count +1 per tick; on the tick where count reaches HOLD_TICKS -> RAMP_DOWN.
REQ-022 RAMP_DOWN on tick: duty == 0 -> NEXT; else duty <= mode_q ? duty-1 : 0.
REQ-023 NEXT, exactly one cycle: step_done = 1; step <= (step == NUM_CH) ? 0 : step+1; mode_q <= mode; -> RAMP_UP.
REQ-024 Duty SHALL never exceed DUTY_MAX nor underflow below 0.
REQ-025 mode changes SHALL take effect only at IDLE exit or NEXT, never mid-ramp.
REQ-026 enable = 0 in any non-IDLE state -> IDLE next cycle: duty 0, step 0, prescaler 0, pwm low one cycle later.
REQ-027 enable = 0 coinciding with a tick or NEXT: enable wins, no step_done pulse.

Reset
REQ-028 rst = 1 SHALL force state IDLE, duty 0, step 0, prescaler 0, PWM counter 0, hold count 0, mode_q 0.
REQ-029 Outputs SHALL be pwm = 0, step = 0, step_done = 0, busy = 0 in the cycle after rst is sampled high; rst overrides enable.

Configuration
REQ-030 Macro RGB_SEQ_HOLD_EN defined: HOLD state and hold counter built as in REQ-021.
REQ-031 RGB_SEQ_HOLD_EN undefined: no HOLD state or counter; RAMP_UP at duty == DUTY_MAX on tick -> RAMP_DOWN directly; HOLD_TICKS ignored.

Structure
REQ-032 Shared package rgb_seq_pkg SHALL hold the FSM state enum and mode encodings (MODE_BLINK = 0, MODE_BREATHE = 1).
REQ-033 Per-channel compare/register SHALL be sub-module rgb_pwm_chan, instantiated NUM_CH times; prescaler, PWM counter and FSM stay in the top.

Verification (NUM_CH=3, PWM_W=4, DUTY_MAX=15, PRESC_MAX=3, HOLD_TICKS=2)
REQ-034 rst high for 2 cycles with enable = 1 -> all outputs 0, busy 0; first step_done no earlier than the full step time after rst release.
REQ-035 Blink, HOLD_EN: enable at cycle 0 -> RAMP_UP at cycle 1; duty 15 at first tick (cycle 4); step_done period = 6 ticks + 1 = 25 cycles; step sequence 0,1,2,3,0.
REQ-036 Breathe: duty rises 0..15 one per tick, holds 2 ticks, falls 15..0; pwm[step] high count per 16-cycle frame equals duty; step 3 -> pwm == 0.
REQ-037 Toggle mode mid-RAMP_UP -> ramp shape unchanged until next step_done, new mode applied afterwards.
REQ-038 Deassert enable during HOLD -> busy 0 next cycle, pwm 0 the cycle after, no step_done; re-enable restarts at step 0.
REQ-039 Build without RGB_SEQ_HOLD_EN, blink -> step_done period = 4 ticks + 1 = 17 cycles.

Source files
------------

// File: rtl/rgb_seq_pkg.sv
// rtl/rgb_seq_pkg.sv - sequencer FSM states and mode encodings; HOLD exists only with RGB_SEQ_HOLD_EN
package rgb_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
`ifdef RGB_SEQ_HOLD_EN
        HOLD,
`endif
        RAMP_DOWN,
        NEXT
    } seq_state_e;

    localparam logic MODE_BLINK   = 1'b0;
    localparam logic MODE_BREATHE = 1'b1;

endpackage

// File: rtl/rgb_pwm_chan.sv
// rtl/rgb_pwm_chan.sv - one registered PWM compare output, lit only while its step is selected
module rgb_pwm_chan #(
    parameter int PWM_W  = 8,
    parameter int STEP_W = 2,
    parameter int CH_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [STEP_W-1:0] step,
    input  logic [PWM_W-1:0]  pwm_cnt,
    input  logic [PWM_W-1:0]  duty,
    output logic              pwm
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm <= 1'b0;
        end else begin
            pwm <= active && (step == STEP_W'(CH_IDX)) && (pwm_cnt < duty);
        end
    end

endmodule

// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - steps through LED channels with blink/breathe duty profiles
// RGB_SEQ_HOLD_EN: when defined, the duty dwells at peak for HOLD_TICKS ticks
module rgb_pwm_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_W      = 8,
    parameter int DUTY_MAX   = 255,
    parameter int PRESC_MAX  = 46874,
    parameter int HOLD_TICKS = 64
) (
    input  logic                       int_osc,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       mode,
    output logic [NUM_CH-1:0]          pwm,
    output logic [$clog2(NUM_CH+1)-1:0] step,
    output logic                       step_done,
    output logic                       busy
);

    localparam int STEP_W  = $clog2(NUM_CH + 1);
    localparam int PRESC_W = $clog2(PRESC_MAX + 2);
    localparam logic [PWM_W-1:0]   DUTY_PEAK  = PWM_W'(DUTY_MAX);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_MAX);
    localparam logic [STEP_W-1:0]  STEP_OFF   = STEP_W'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > 8 || DUTY_MAX < 1 || DUTY_MAX > (1 << PWM_W) - 1 ||
        HOLD_TICKS < 1 || HOLD_TICKS > 65535 || PRESC_MAX < 0) begin : g_bad_param
        $error("rgb_pwm_sequencer: parameter out of range");
    end

    seq_state_e         state, state_d;
    logic [PWM_W-1:0]   pwm_cnt;
    logic [PWM_W-1:0]   duty, duty_d;
    logic [PRESC_W-1:0] presc, presc_d;
    logic [STEP_W-1:0]  step_d;
    logic               mode_q, mode_q_d;
    logic               tick;
`ifdef RGB_SEQ_HOLD_EN
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    logic [15:0]        hold_cnt, hold_cnt_d;
`endif

    always_comb begin
        state_d  = state;
        duty_d   = duty;
        step_d   = step;
        mode_q_d = mode_q;
        tick     = (presc == PRESC_LAST);
        presc_d  = tick ? '0 : presc + 1'b1;
`ifdef RGB_SEQ_HOLD_EN
        hold_cnt_d = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                tick    = 1'b0;
                presc_d = '0;
                duty_d  = '0;
                step_d  = '0;
                if (enable) begin
                    state_d  = RAMP_UP;
                    mode_q_d = mode;
                end
            end
            RAMP_UP: if (tick) begin
                if (duty == DUTY_PEAK) begin
`ifdef RGB_SEQ_HOLD_EN
                    state_d    = HOLD;
                    hold_cnt_d = '0;
`else
                    state_d    = RAMP_DOWN;
`endif
                end else begin
                    duty_d = (mode_q == MODE_BREATHE) ? duty + 1'b1 : DUTY_PEAK;
                end
            end
`ifdef RGB_SEQ_HOLD_EN
            HOLD: if (tick) begin
                hold_cnt_d = hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST) state_d = RAMP_DOWN;
            end
`endif
            RAMP_DOWN: if (tick) begin
                if (duty == '0) state_d = NEXT;
                else            duty_d  = (mode_q == MODE_BREATHE) ? duty - 1'b1 : '0;
            end
            NEXT: begin
                // restart the prescaler so every step lasts a whole number of ticks plus this cycle
                presc_d  = '0;
                state_d  = RAMP_UP;
                step_d   = (step == STEP_OFF) ? '0 : step + 1'b1;
                mode_q_d = mode;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            duty_d  = '0;
            step_d  = '0;
            presc_d = '0;
        end
    end

    always_ff @(posedge int_osc) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            step     <= '0;
            presc    <= '0;
            pwm_cnt  <= '0;
            mode_q   <= MODE_BLINK;
`ifdef RGB_SEQ_HOLD_EN
            hold_cnt <= '0;
`endif
        end else begin
            state    <= state_d;
            duty     <= duty_d;
            step     <= step_d;
            presc    <= presc_d;
            pwm_cnt  <= pwm_cnt + 1'b1;
            mode_q   <= mode_q_d;
`ifdef RGB_SEQ_HOLD_EN
            hold_cnt <= hold_cnt_d;
`endif
        end
    end

    assign busy      = (state != IDLE);
    assign step_done = (state == NEXT) && enable;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        rgb_pwm_chan #(
            .PWM_W  (PWM_W),
            .STEP_W (STEP_W),
            .CH_IDX (i)
        ) u_chan (
            .clk     (int_osc),
            .rst     (rst),
            .active  (busy),
            .step    (step),
            .pwm_cnt (pwm_cnt),
            .duty    (duty),
            .pwm     (pwm[i])
        );
    end

endmodule
